// File: rtl/vedic_mult_pipe.sv
// Pipelined W x W Urdhva-Tiryagbhyam (vertical-crosswise) multiplier with valid/ready
// back-pressure and a side-band tag; define VEDIC_MULT_OPCNT_EN to add the op_cnt port.
module vedic_mult_pipe #(
  parameter int W      = 24,
  parameter int STAGES = 3,
  parameter int TAG_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag
`ifdef VEDIC_MULT_OPCNT_EN
  ,
  output logic [31:0]      op_cnt
`endif
);
  localparam int PW   = 2 * W;
  localparam int NCOL = 2 * W - 1;
  localparam int G    = (NCOL + STAGES - 1) / STAGES;
  localparam int CW   = $clog2(2 * W) + 1;

  // Popcount of the crosswise diagonal i+j=k, i.e. sum of a[i] & b[k-i].
  // b is bit-reversed so the diagonal becomes a plain shift of br against a.
  function automatic logic [CW-1:0] col_count(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input int k);
    logic [W-1:0]  br;
    logic [W-1:0]  d;
    logic [CW-1:0] cnt;
    br = {<<{b}};
    if (k <= W - 1) d = a & (br >> (W - 1 - k));
    else            d = a & (br << (k - W + 1));
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(d[0]);
      d   = d >> 1;
    end
    return cnt;
  endfunction

  // Slice s of each bus is what stage s consumes; slice 0 comes straight from the ports.
  logic [STAGES*W-1:0]     stg_a;
  logic [STAGES*W-1:0]     stg_b;
  logic [STAGES*CW-1:0]    stg_c;
  logic [STAGES*PW-1:0]    stg_p;
  logic [STAGES*TAG_W-1:0] stg_t;
  logic [STAGES:0]         stg_v;
  logic [STAGES-1:0]       adv;

  logic             out_valid_q;
  logic [PW-1:0]    out_p_q;
  logic [TAG_W-1:0] out_tag_q;

  assign stg_a[W-1:0]     = in_a;
  assign stg_b[W-1:0]     = in_b;
  assign stg_c[CW-1:0]    = '0;
  assign stg_p[PW-1:0]    = '0;
  assign stg_t[TAG_W-1:0] = in_tag;
  assign stg_v[0]         = in_valid;
  assign stg_v[STAGES]    = out_valid_q;

  // Stage s moves when any register from s to the output is empty or the consumer takes
  // the output; written flat so no combinational loop runs through adv.
  for (genvar s = 0; s < STAGES; s++) begin : g_adv
    assign adv[s] = out_ready || !(&stg_v[STAGES:s+1]);
  end

  assign in_ready  = adv[0];
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign out_tag   = out_tag_q;

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int LO = (s * G < NCOL) ? s * G : NCOL;
    localparam int HI = ((s + 1) * G < NCOL) ? (s + 1) * G : NCOL;
    localparam int NC = HI - LO;

    logic [W-1:0]         a_in;
    logic [W-1:0]         b_in;
    logic [PW-1:0]        p_in;
    logic [TAG_W-1:0]     t_in;
    logic [CW*(NC+1)-1:0] cch;
    logic [PW-1:0]        colbits;
    logic [PW-1:0]        p_res;
    logic                 load;

    assign a_in          = stg_a[s*W +: W];
    assign b_in          = stg_b[s*W +: W];
    assign p_in          = stg_p[s*PW +: PW];
    assign t_in          = stg_t[s*TAG_W +: TAG_W];
    assign cch[CW-1:0]   = stg_c[s*CW +: CW];
    assign load          = adv[s] && stg_v[s];

    // Ripple the carry through this stage's group of columns.
    for (genvar n = 0; n < PW; n++) begin : g_col
      if (n >= LO && n < HI) begin : g_act
        logic [CW-1:0] sum;
        assign sum                         = cch[(n-LO)*CW +: CW] + col_count(a_in, b_in, n);
        assign colbits[n]                  = sum[0];
        assign cch[(n-LO+1)*CW +: CW]      = sum >> 1;
      end else begin : g_idle
        assign colbits[n] = 1'b0;
      end
    end

    if (s < STAGES - 1) begin : g_mid
      logic             vld_q, vld_d;
      logic [W-1:0]     a_q, a_d;
      logic [W-1:0]     b_q, b_d;
      logic [CW-1:0]    c_q, c_d;
      logic [PW-1:0]    p_q, p_d;
      logic [TAG_W-1:0] t_q, t_d;

      assign p_res = p_in | colbits;

      always_comb begin
        vld_d = adv[s] ? stg_v[s] : vld_q;
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        p_d   = p_q;
        t_d   = t_q;
        if (load) begin
          a_d = a_in;
          b_d = b_in;
          c_d = cch[NC*CW +: CW];
          p_d = p_res;
          t_d = t_in;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          c_q   <= '0;
          p_q   <= '0;
          t_q   <= '0;
        end else begin
          vld_q <= vld_d;
          a_q   <= a_d;
          b_q   <= b_d;
          c_q   <= c_d;
          p_q   <= p_d;
          t_q   <= t_d;
        end
      end

      assign stg_v[s+1]                 = vld_q;
      assign stg_a[(s+1)*W +: W]         = a_q;
      assign stg_b[(s+1)*W +: W]         = b_q;
      assign stg_c[(s+1)*CW +: CW]       = c_q;
      assign stg_p[(s+1)*PW +: PW]       = p_q;
      assign stg_t[(s+1)*TAG_W +: TAG_W] = t_q;
    end else begin : g_last
      logic             out_valid_d;
      logic [PW-1:0]    out_p_d;
      logic [TAG_W-1:0] out_tag_d;

      // The final carry out of the top column is at most 1 and lands on the product MSB.
      assign p_res = p_in | colbits | (PW'(cch[NC*CW +: CW]) << (PW - 1));

      always_comb begin
        out_valid_d = adv[s] ? stg_v[s] : out_valid_q;
        out_p_d     = out_p_q;
        out_tag_d   = out_tag_q;
        if (load) begin
          out_p_d   = p_res;
          out_tag_d = t_in;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          out_p_q     <= '0;
          out_tag_q   <= '0;
        end else begin
          out_valid_q <= out_valid_d;
          out_p_q     <= out_p_d;
          out_tag_q   <= out_tag_d;
        end
      end
    end
  end

`ifdef VEDIC_MULT_OPCNT_EN
  logic [31:0] op_cnt_q, op_cnt_d;

  always_comb begin
    op_cnt_d = op_cnt_q;
    if (in_valid && in_ready) op_cnt_d = op_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_cnt_q <= '0;
    else        op_cnt_q <= op_cnt_d;
  end

  assign op_cnt = op_cnt_q;
`endif

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Self-checking bench for vedic_mult_pipe (W=9, STAGES=3): directed table, streaming,
// back-pressure, mid-flight reset and randomised traffic against an a*b scoreboard.
module tb_vedic_mult_pipe;
  localparam int W      = 9;
  localparam int STAGES = 3;
  localparam int TAG_W  = 10;
  localparam int PW     = 2 * W;
  localparam int NRAND  = 3000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out_p;
  logic [TAG_W-1:0] out_tag;
`ifdef VEDIC_MULT_OPCNT_EN
  logic [31:0]      op_cnt;
`endif

  vedic_mult_pipe #(.W(W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag)
`ifdef VEDIC_MULT_OPCNT_EN
    ,
    .op_cnt    (op_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0]    p;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [TAG_W-1:0] tag;
    logic [PW-1:0]    p;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];

  int errors     = 0;
  int checks     = 0;
  int cyc        = 0;
  int acc_total  = 0;
  int emit_cnt   = 0;
  int first_emit = -1;
  int last_emit  = -1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Called at a falling edge with inputs already driven; evaluates this cycle's
  // handshakes against the model, then advances to the next falling edge.
  task automatic step();
    exp_t e;
    #1;
    chk("in_ready", 64'(in_ready), 64'(out_ready || (sb.size() < STAGES)));
    if (out_valid) begin
      chk("out_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        chk("out_p", 64'(out_p), 64'(sb[0].p));
        chk("out_tag", 64'(out_tag), 64'(sb[0].tag));
        if (out_ready) begin
          void'(sb.pop_front());
          emit_cnt++;
          if (first_emit < 0) first_emit = cyc;
          last_emit = cyc;
        end
      end
    end
    if (in_valid && in_ready) begin
      e.p   = PW'(in_a) * PW'(in_b);
      e.tag = in_tag;
      sb.push_back(e);
      acc_total++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int first_acc;
    int prev;
    int i;
    int k;
    int sent;
    int n;

    tbl[0] = '{9'd511, 9'd511, 10'h155, 18'd261121};
    tbl[1] = '{9'd0,   9'd400, 10'h001, 18'd0};
    tbl[2] = '{9'd1,   9'd367, 10'h2AA, 18'd367};
    tbl[3] = '{9'd256, 9'd2,   10'h3FF, 18'd512};
    tbl[4] = '{9'd300, 9'd200, 10'h123, 18'd60000};
    tbl[5] = '{9'd511, 9'd1,   10'h000, 18'd511};
    tbl[6] = '{9'd123, 9'd456, 10'h0F0, 18'd56088};
    tbl[7] = '{9'd255, 9'd257, 10'h30C, 18'd65535};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_p", 64'(out_p), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
`ifdef VEDIC_MULT_OPCNT_EN
    chk("rst_op_cnt", 64'(op_cnt), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Directed vectors, one at a time, with latency measured from the accept edge.
    for (int t = 0; t < 8; t++) begin
      in_valid  = 1'b1;
      in_a      = tbl[t].a;
      in_b      = tbl[t].b;
      in_tag    = tbl[t].tag;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        step();
        lat++;
      end
      chk("tbl_latency", 64'(lat), 64'(STAGES));
      chk("tbl_p", 64'(out_p), 64'(tbl[t].p));
      chk("tbl_tag", 64'(out_tag), 64'(tbl[t].tag));
      step();
      chk("tbl_idle", 64'(sb.size()), 64'd0);
    end

    // Back-to-back squares 1..16 with the consumer always ready.
    emit_cnt   = 0;
    first_emit = -1;
    last_emit  = -1;
    first_acc  = cyc;
    for (int v = 1; v <= 16; v++) begin
      in_valid  = 1'b1;
      in_a      = W'(v);
      in_b      = W'(v);
      in_tag    = TAG_W'(v);
      out_ready = 1'b1;
      step();
    end
    chk("stream_accepts", 64'(cyc - first_acc), 64'd16);
    drain(50);
    chk("stream_emits", 64'(emit_cnt), 64'd16);
    chk("stream_first_lat", 64'(first_emit - first_acc), 64'(STAGES));
    chk("stream_consecutive", 64'(last_emit - first_emit), 64'd15);

    // Ten operations with the consumer stalled for six cycles mid-stream.
    emit_cnt = 0;
    i = 0;
    k = 0;
    while (i < 10 && k < 100) begin
      in_valid  = 1'b1;
      in_a      = W'((i * 53 + 7) % 512);
      in_b      = W'((i * 29 + 100) % 512);
      in_tag    = TAG_W'(i + 16);
      out_ready = !(k >= 3 && k < 9);
      prev = acc_total;
      step();
      k++;
      if (acc_total != prev) i++;
    end
    chk("bp_all_accepted", 64'(i), 64'd10);
    drain(50);
    chk("bp_emits", 64'(emit_cnt), 64'd10);

    // Two operations in flight, then reset before either reaches the output.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 9'd100;
    in_b      = 9'd200;
    in_tag    = 10'h0AA;
    step();
    in_a   = 9'd3;
    in_b   = 9'd5;
    in_tag = 10'h055;
    step();
    in_valid = 1'b0;
    chk("rstmid_pre_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", 64'(out_valid), 64'd0);
    chk("rstmid_out_p", 64'(out_p), 64'd0);
    chk("rstmid_out_tag", 64'(out_tag), 64'd0);
    sb.delete();
    acc_total = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstmid_in_ready", 64'(in_ready), 64'd1);
`ifdef VEDIC_MULT_OPCNT_EN
    chk("rstmid_op_cnt", 64'(op_cnt), 64'd0);
`endif
    @(negedge clk);
    repeat (10) step();
    chk("rstmid_no_ghost", 64'(out_valid), 64'd0);

    // Randomised traffic with random consumer stalls; valid held until accepted.
    emit_cnt = 0;
    sent = 0;
    n = 0;
    in_valid = 1'b0;
    while ((sent < NRAND || sb.size() != 0) && n < 30000) begin
      if (!in_valid && sent < NRAND && $urandom_range(0, 4) != 0) begin
        in_valid = 1'b1;
        in_a     = ($urandom_range(0, 9) == 0) ? 9'd511 : W'($urandom_range(0, 511));
        in_b     = ($urandom_range(0, 9) == 0) ? 9'd511 : W'($urandom_range(0, 511));
        in_tag   = TAG_W'($urandom_range(0, 1023));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      prev = acc_total;
      step();
      n++;
      if (acc_total != prev) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    chk("rand_sent", 64'(sent), 64'(NRAND));
    chk("rand_drained", 64'(sb.size()), 64'd0);
    chk("rand_emits", 64'(emit_cnt), 64'(NRAND));
`ifdef VEDIC_MULT_OPCNT_EN
    chk("rand_op_cnt", 64'(op_cnt), 64'(acc_total));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
